// File: rtl/spi_display_sink_pkg.sv
// spi_display_sink shared types.
// Receiver state and held-word layout.
package spi_display_sink_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } word_t;

endpackage

// File: rtl/spi_display_sink_sync.sv
// Pin synchronizer with a delayed copy.
// edge_o pulses for one clock whenever the synced level changes.
module sync_edge #(
  parameter int unsigned SYNC = 2,
  parameter logic        RST  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic edge_o
);

  logic [SYNC-1:0] s_q;
  logic            p_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= {SYNC{RST}};
      p_q <= RST;
    end else begin
      s_q <= {s_q[SYNC-2:0], d_i};
      p_q <= s_q[SYNC-1];
    end
  end

  assign q_o    = s_q[SYNC-1];
  assign edge_o = s_q[SYNC-1] ^ p_q;

endmodule

// File: rtl/spi_display_sink.sv
// SPI display link receiver: oversampled mode-0 slave that
// rebuilds {dc, byte} words behind an empty/get pull port.
module spi_display_sink
  import spi_display_sink_pkg::*;
#(
  parameter int unsigned SYNC = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       spi_cs_n,
  input  logic       spi_clock,
  input  logic       spi_dc,
  input  logic       spi_mosi,
  output logic       dc,
  output logic [7:0] data,
  output logic       empty,
  input  logic       get,
  output logic       overrun,
  output logic       frame_err,
  input  logic       err_clear
);

  logic cs_s, cs_e, sck_s, sck_e;
  logic [SYNC-1:0] mosi_q, dc_q;

  sync_edge #(.SYNC(SYNC), .RST(1'b1)) u_cs (
    .clk_i (clock),
    .rst_ni(reset_n),
    .d_i   (spi_cs_n),
    .q_o   (cs_s),
    .edge_o(cs_e)
  );

  sync_edge #(.SYNC(SYNC), .RST(1'b0)) u_sck (
    .clk_i (clock),
    .rst_ni(reset_n),
    .d_i   (spi_clock),
    .q_o   (sck_s),
    .edge_o(sck_e)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mosi_q <= '0;
      dc_q   <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC-2:0], spi_mosi};
      dc_q   <= {dc_q[SYNC-2:0], spi_dc};
    end
  end

  logic cs_fall, cs_rise, sck_rise;
  assign cs_fall  = cs_e & ~cs_s;
  assign cs_rise  = cs_e & cs_s;
  assign sck_rise = sck_e & sck_s;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  word_t      hold_q, hold_d;
  logic       empty_q, empty_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       done, ovr_set, ferr_set;
  word_t      word;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    hold_d   = hold_q;
    empty_d  = empty_q;
    done     = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    word     = '{dc: dc_q[SYNC-1],
                 data: {sh_q, mosi_q[SYNC-1]}};
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_d    = '0;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          sh_d  = {sh_q[5:0], mosi_q[SYNC-1]};
          cnt_d = cnt_q + 3'd1;
          done  = (cnt_q == 3'd7);
        end
        // A completing edge leaves cnt_d at 0, so no frame error.
        if (cs_rise) begin
          state_d  = IDLE;
          ferr_set = (cnt_d != 3'd0);
          cnt_d    = '0;
          sh_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      if (empty_q || get) begin
        hold_d  = word;
        empty_d = 1'b0;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (get && !empty_q) begin
      empty_d = 1'b1;
    end
    ovr_d  = ovr_set | (ovr_q & ~err_clear);
    ferr_d = ferr_set | (ferr_q & ~err_clear);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      hold_q  <= '0;
      empty_q <= 1'b1;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      empty_q <= empty_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign dc        = hold_q.dc;
  assign data      = hold_q.data;
  assign empty     = empty_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_display_sink.sv
// Directed bench for spi_display_sink: bit-banged frames,
// scoreboard queue drained by an auto-get monitor.
module tb_spi_display_sink;

  localparam int unsigned SYNC = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_clock = 1'b0;
  logic       spi_dc = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       dc;
  logic [7:0] data;
  logic       empty;
  logic       get;
  logic       overrun;
  logic       frame_err;
  logic       err_clear = 1'b0;

  logic mon_get = 1'b0;
  logic man_get = 1'b0;
  logic auto_get = 1'b0;
  assign get = mon_get | man_get;

  int n_chk = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  always #5 clock = ~clock;

  spi_display_sink #(.SYNC(SYNC)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .spi_cs_n (spi_cs_n),
    .spi_clock(spi_clock),
    .spi_dc   (spi_dc),
    .spi_mosi (spi_mosi),
    .dc       (dc),
    .data     (data),
    .empty    (empty),
    .get      (get),
    .overrun  (overrun),
    .frame_err(frame_err),
    .err_clear(err_clear)
  );

  task automatic chk(input string name, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_get();
    man_get = 1'b1;
    tick(1);
    man_get = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
  endtask

  // mode 1: latency check on the last bit; mode 2: get on completion
  task automatic send_bits(input logic d, input logic [7:0] b,
                           input int nb, input int mode);
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi  = b[i];
      spi_dc    = d;
      tick(4);
      spi_clock = 1'b1;
      if (i == 0 && mode == 1) begin
        tick(SYNC);
        chk("latency_pre", int'(empty), 1);
        tick(1);
        chk("latency_fall", int'(empty), 0);
        tick(4 - SYNC - 1);
      end else if (i == 0 && mode == 2) begin
        tick(SYNC);
        man_get = 1'b1;
        tick(1);
        man_get = 1'b0;
        tick(4 - SYNC - 1);
      end else begin
        tick(4);
      end
      spi_clock = 1'b0;
    end
  endtask

  task automatic frame_start();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    tick(4);
    spi_cs_n = 1'b1;
    tick(4);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || !empty); i++)
      tick(1);
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge clock);
      if (auto_get && !empty && !mon_get) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, want none",
                   {dc, data});
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", int'({dc, data}), int'(e));
        end
        mon_get = 1'b1;
      end else begin
        mon_get = 1'b0;
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_empty", int'(empty), 1);
    chk("rst_data", int'(data), 0);
    chk("rst_dc", int'(dc), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_ferr", int'(frame_err), 0);
    reset_n = 1'b1;
    tick(4);

    frame_start();
    send_bits(1'b0, 8'hA5, 8, 1);
    frame_end();
    chk("cmd_dc", int'(dc), 0);
    chk("cmd_data", int'(data), 'hA5);
    chk("cmd_empty", int'(empty), 0);
    pulse_get();
    chk("cmd_get_empty", int'(empty), 1);

    frame_start();
    send_bits(1'b1, 8'h77, 8, 0);
    send_bits(1'b0, 8'h66, 8, 0);
    send_bits(1'b0, 8'h00, 4, 0);
    chk("pre_rst_data", int'(data), 'h77);
    chk("pre_rst_ovr", int'(overrun), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_data", int'(data), 0);
    chk("mid_rst_dc", int'(dc), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    chk("mid_rst_ferr", int'(frame_err), 0);
    spi_cs_n  = 1'b1;
    spi_clock = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(4);
    auto_get = 1'b1;
    exp_q.push_back(9'h03C);
    frame_start();
    send_bits(1'b0, 8'h3C, 8, 0);
    frame_end();
    drain();

    exp_q.push_back(9'h02A);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h1FF);
    frame_start();
    send_bits(1'b0, 8'h2A, 8, 0);
    send_bits(1'b1, 8'h00, 8, 0);
    send_bits(1'b1, 8'hFF, 8, 0);
    frame_end();
    drain();
    chk("loop_ovr", int'(overrun), 0);
    chk("loop_ferr", int'(frame_err), 0);
    auto_get = 1'b0;
    tick(2);

    frame_start();
    send_bits(1'b0, 8'h11, 8, 0);
    send_bits(1'b0, 8'h22, 8, 0);
    frame_end();
    chk("ovr_data", int'(data), 'h11);
    chk("ovr_flag", int'(overrun), 1);
    pulse_clear();
    chk("ovr_clear", int'(overrun), 0);
    chk("ovr_keep", int'(data), 'h11);
    pulse_get();
    chk("ovr_get_empty", int'(empty), 1);

    frame_start();
    send_bits(1'b0, 8'h11, 8, 0);
    send_bits(1'b0, 8'h22, 8, 2);
    frame_end();
    chk("same_empty", int'(empty), 0);
    chk("same_data", int'(data), 'h22);
    chk("same_ovr", int'(overrun), 0);
    pulse_get();

    frame_start();
    send_bits(1'b1, 8'hF8, 5, 0);
    frame_end();
    chk("ferr_flag", int'(frame_err), 1);
    chk("ferr_empty", int'(empty), 1);
    pulse_clear();
    chk("ferr_clear", int'(frame_err), 0);
    auto_get = 1'b1;
    exp_q.push_back(9'h081);
    frame_start();
    send_bits(1'b0, 8'h81, 8, 0);
    frame_end();
    drain();
    chk("ferr_after", int'(frame_err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
